// File: rtl/tmds_channel_decoder.sv
// One TMDS lane receiver: bit-slip word alignment on control-token runs,
// then a two-stage pipeline from aligned word to decoded VD/CD/VDE.
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 2048
) (
  input  logic       pixclk,
  input  logic       resetn,
  input  logic [9:0] raw,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RW   = $clog2(CTRL_RUN + 1);
  localparam int DMAX = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
  localparam int DW   = $clog2(DMAX);

  typedef enum logic {SEARCH, LOCKED} state_t;

  typedef struct packed {
    logic       vde;
    logic [1:0] cd;
    logic [7:0] vd;
  } dec_t;

  function automatic dec_t decode(input logic [9:0] w);
    dec_t       r;
    logic [7:0] d;
    r = '0;
    d = w[9] ? ~w[7:0] : w[7:0];
    case (w)
      10'b1101010100: r.cd = 2'b00;
      10'b0010101011: r.cd = 2'b01;
      10'b0101010100: r.cd = 2'b10;
      10'b1010101011: r.cd = 2'b11;
      default: begin
        r.vde   = 1'b1;
        r.vd[0] = d[0];
        for (int i = 1; i < 8; i++)
          r.vd[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
    endcase
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [9:0]      raw_prev, w1, w1_prev;
  logic [19:0]     window;
  logic [RW-1:0]   run;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic [1:0]      disc;
  logic [3:0]      offset_nxt;
  logic            slip, run_full, is_tok;
  dec_t            dec1;

  assign window   = {raw, raw_prev};
  assign dec1     = decode(w1);
  assign is_tok   = ~dec1.vde;
  assign run_full = (run == RW'(CTRL_RUN));
  assign locked   = (state == LOCKED);

  // Stage 1: aligned word plus run tracking. After a slip the pipeline
  // still holds words from the old offset, so two words are ignored.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      raw_prev <= '0;
      w1       <= '0;
      w1_prev  <= '0;
      run      <= '0;
      disc     <= '0;
    end else begin
      raw_prev <= raw;
      w1       <= window[offset +: 10];
      w1_prev  <= w1;
      if (slip) begin
        run  <= '0;
        disc <= 2'd2;
      end else if (disc != 2'd0) begin
        run  <= '0;
        disc <= disc - 2'd1;
      end else if (!is_tok)       run <= '0;
      else if (w1 != w1_prev)     run <= RW'(1);
      else if (!run_full)         run <= run + RW'(1);
    end
  end

  // A full run always wins over an expiring dwell timer.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell + DW'(1);
    slip      = 1'b0;
    case (state)
      SEARCH: begin
        if (run_full) begin
          state_nxt = LOCKED;
          dwell_nxt = '0;
        end else if (dwell == DW'(SEARCH_TIMEOUT - 1)) begin
          slip      = 1'b1;
          dwell_nxt = '0;
        end
      end
      LOCKED: begin
        if (run_full) begin
          dwell_nxt = '0;
        end else if (dwell == DW'(LOCK_TIMEOUT - 1)) begin
          slip      = 1'b1;
          state_nxt = SEARCH;
          dwell_nxt = '0;
        end
      end
      default: state_nxt = SEARCH;
    endcase
    offset_nxt = slip ? ((offset == 4'd9) ? 4'd0 : offset + 4'd1) : offset;
  end

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      state  <= SEARCH;
      dwell  <= '0;
      offset <= '0;
    end else begin
      state  <= state_nxt;
      dwell  <= dwell_nxt;
      offset <= offset_nxt;
    end
  end

  // Stage 2: decoded outputs, held at zero while searching.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      VD  <= '0;
      CD  <= '0;
      VDE <= 1'b0;
    end else if (state == LOCKED) begin
      VD  <= dec1.vd;
      CD  <= dec1.cd;
      VDE <= dec1.vde;
    end else begin
      VD  <= '0;
      CD  <= '0;
      VDE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench: reference TMDS encoder feeding a lane sliced at bit offset 3.
module tb_tmds_channel_decoder;

  logic       pixclk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] raw    = '0;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       locked;
  logic [3:0] offset;

  tmds_channel_decoder dut (
    .pixclk(pixclk), .resetn(resetn), .raw(raw),
    .VD(VD), .CD(CD), .VDE(VDE), .locked(locked), .offset(offset)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic       vde;
    logic [1:0] cd;
    logic [7:0] vd;
  } exp_t;

  typedef struct {
    logic       vde;
    logic [1:0] cd;
    logic [7:0] vd;
    int         rpt;
  } vec_t;

  int   n_chk = 0, n_fail = 0;
  int   cnt   = 0;
  int   lp    = 0;
  logic [9:0] prev_sym = '0;
  exp_t e0, e1, e2;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic encode(input logic vde, input logic [1:0] cd, input logic [7:0] d,
                        output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    q = '0;
    if (!vde) begin
      cnt = 0;
      case (cd)
        2'b00: q = 10'b1101010100;
        2'b01: q = 10'b0010101011;
        2'b10: q = 10'b0101010100;
        default: q = 10'b1010101011;
      endcase
    end else begin
      n1d   = $countones(d);
      qm    = '0;
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && !d[0])) begin
        for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
        qm[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
        qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (cnt == 0 || n1q == n0q) begin
        q[9]   = ~qm[8];
        q[8]   = qm[8];
        q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
        cnt    = qm[8] ? cnt + n1q - n0q : cnt + n0q - n1q;
      end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
        q[9]   = 1'b1;
        q[8]   = qm[8];
        q[7:0] = ~qm[7:0];
        cnt    = cnt + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
        q[9]   = 1'b0;
        q[8]   = qm[8];
        q[7:0] = qm[7:0];
        cnt    = cnt + n1q - n0q - (qm[8] ? 0 : 2);
      end
    end
  endtask

  // Serialize LSB-first and slice so each symbol starts at bit 3 of a raw word.
  task automatic send(input logic vde, input logic [1:0] cd, input logic [7:0] vd);
    logic [9:0]  sym;
    logic [19:0] cat;
    encode(vde, cd, vd, sym);
    cat      = {sym, prev_sym};
    raw      = cat[16:7];
    prev_sym = sym;
    e2 = e1;
    e1 = e0;
    e0.vde = vde; e0.cd = cd; e0.vd = vd;
    @(posedge pixclk);
    #1;
  endtask

  // 800-symbol line, blanking (CD=00) in the last 160 positions.
  task automatic send_line();
    logic [7:0] px;
    px = 8'(lp) ^ 8'h5A;
    if (lp >= 640) send(1'b0, 2'b00, 8'h00);
    else           send(1'b1, 2'b00, px);
    lp = (lp == 799) ? 0 : lp + 1;
  endtask

  task automatic chk_out(input string nm);
    chk({nm, "_vde"}, int'(VDE), int'(e2.vde));
    if (e2.vde) chk({nm, "_vd"}, int'(VD), int'(e2.vd));
    else        chk({nm, "_cd"}, int'(CD), int'(e2.cd));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vd"}, int'(VD), 0);
    chk({nm, "_cd"}, int'(CD), 0);
    chk({nm, "_vde"}, int'(VDE), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_offset"}, int'(offset), 0);
  endtask

  task automatic wait_lock(input string nm, input int bound);
    int i;
    i = 0;
    while (!locked && i < bound) begin
      send_line();
      i++;
    end
    chk({nm, "_locked"}, int'(locked), 1);
    chk({nm, "_offset"}, int'(offset), 3);
  endtask

  vec_t tbl[8];

  initial begin
    int   bad, fall, changes, last, cur;
    logic [3:0] po;

    tbl[0] = '{1'b1, 2'b00, 8'h00, 1};
    tbl[1] = '{1'b1, 2'b00, 8'h55, 1};
    tbl[2] = '{1'b1, 2'b00, 8'hA5, 1};
    tbl[3] = '{1'b1, 2'b00, 8'hFF, 1};
    tbl[4] = '{1'b1, 2'b00, 8'h10, 1};
    tbl[5] = '{1'b0, 2'b01, 8'h00, 20};
    tbl[6] = '{1'b0, 2'b10, 8'h00, 20};
    tbl[7] = '{1'b0, 2'b11, 8'h00, 20};
    e0 = '{1'b0, 2'b00, 8'h00}; e1 = e0; e2 = e0;

    for (int i = 0; i < 4; i++) send(1'b0, 2'b00, 8'h00);
    chk_zero("reset");

    // Initial acquisition from offset 0.
    resetn = 1'b1;
    lp = 0;
    wait_lock("acquire", 3 * 1024 + 16 + 4);
    bad = 0;
    for (int i = 0; i < 1600; i++) begin
      send_line();
      if (!locked || offset != 4'd3) bad++;
    end
    chk("hold_offset", bad, 0);

    for (int i = 0; i < 20; i++) send(1'b0, 2'b00, 8'h00);
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].rpt; r++) begin
        send(tbl[k].vde, tbl[k].cd, tbl[k].vd);
        chk_out($sformatf("vec%0d", k));
      end
      if (!tbl[k].vde) chk($sformatf("vec%0d_locked", k), int'(locked), 1);
    end
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 2'b11, 8'h00);
      chk_out("flush");
    end

    // Data without blanking: lock must time out and slip to offset 4.
    fall = -1; bad = 0;
    for (int i = 0; i < 2100; i++) begin
      send(1'b1, 2'b00, 8'(i));
      if (fall < 0 && !locked) fall = i;
      if (fall < 0 && offset != 4'd3) bad++;
    end
    chk("drop_window", int'(fall >= 2048 && fall <= 2052), 1);
    chk("drop_offset_held", bad, 0);
    chk("drop_locked", int'(locked), 0);
    chk("drop_offset", int'(offset), 4);

    // Blanking restored: walk 4..9,0..3 and relock.
    po = offset; bad = 0; changes = 0;
    for (int i = 0; i < 11000 && !locked; i++) begin
      send_line();
      if (offset != po) begin
        changes++;
        if (offset != ((po == 4'd9) ? 4'd0 : po + 4'd1)) bad++;
        po = offset;
      end
    end
    chk("relock_seq", bad, 0);
    chk("relock_slips", changes, 9);
    chk("relock_locked", int'(locked), 1);
    chk("relock_offset", int'(offset), 3);

    // Runs of 15 tokens never lock; slips every SEARCH_TIMEOUT cycles.
    resetn = 1'b0;
    send(1'b0, 2'b00, 8'h00);
    chk_zero("reset2");
    resetn = 1'b1;
    po = offset; bad = 0; changes = 0; last = -1; cur = 0;
    for (int i = 0; i < 10 * 1024 + 50; i++) begin
      if (cur == 15) send(1'b1, 2'b00, 8'h3C);
      else           send(1'b0, 2'b00, 8'h00);
      cur = (cur == 15) ? 0 : cur + 1;
      if (locked) bad++;
      if (offset != po) begin
        changes++;
        if (i - last != 1024) bad++;
        if (offset != ((po == 4'd9) ? 4'd0 : po + 4'd1)) bad++;
        last = i;
        po = offset;
      end
    end
    chk("run15_errors", bad, 0);
    chk("run15_slips", changes, 10);
    chk("run15_offset", int'(offset), 0);

    // Reset pulse while locked in the active region.
    wait_lock("pre_pulse", 4200);
    for (int i = 0; i < 2000 && lp != 300; i++) send_line();
    chk("pulse_vde_before", int'(VDE), 1);
    #2 resetn = 1'b0;
    #1 chk_zero("pulse");
    send_line();
    send_line();
    resetn = 1'b1;
    wait_lock("post_pulse", 4200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
